// File: rtl/keccak_sponge_ctrl.sv
// Sponge front-end for the Keccak permutation: absorbs a 64-bit lane stream with pad10*1,
// sequences one permutation per rate block, then squeezes the digest lanes out.
module keccak_sponge_ctrl #(
    parameter int unsigned RATE_LANES = 17,
    parameter int unsigned OUT_LANES  = 4,
    parameter logic [7:0]  DSUFFIX    = 8'h06
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        msg_valid_i,
    output logic        msg_ready_o,
    input  logic [63:0] msg_data_i,
    input  logic        msg_last_i,
    input  logic [3:0]  msg_bytes_i,
    output logic        state_clr_o,
    output logic        lane_we_o,
    output logic [4:0]  lane_idx_o,
    output logic [63:0] lane_xor_o,
    input  logic [63:0] lane_rdata_i,
    input  logic        perm_ready_i,
    output logic        perm_start_o,
    input  logic        perm_done_i,
    output logic        dig_valid_o,
    input  logic        dig_ready_i,
    output logic [63:0] dig_data_o,
    output logic        dig_last_o,
    output logic        busy_o
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CLEAR     = 3'd1;
    localparam logic [2:0] S_ABSORB    = 3'd2;
    localparam logic [2:0] S_PAD       = 3'd3;
    localparam logic [2:0] S_FINAL     = 3'd4;
    localparam logic [2:0] S_PERM_REQ  = 3'd5;
    localparam logic [2:0] S_PERM_WAIT = 3'd6;
    localparam logic [2:0] S_SQUEEZE   = 3'd7;

    localparam logic [4:0] LAST_RATE = 5'(RATE_LANES - 1);
    localparam logic [4:0] LAST_OUT  = 5'(OUT_LANES - 1);

    logic [2:0]  state_q, state_d;
    logic [4:0]  lane_cnt_q, lane_cnt_d;
    logic        pad_pend_q, pad_pend_d;
    logic        last_seen_q, last_seen_d;
    logic [63:0] last_xor;
    logic [31:0] nbytes;

    assign nbytes = 32'(msg_bytes_i);

    // Partial last lane: keep the valid bytes and drop the suffix into the first free byte.
    always_comb begin
        last_xor = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (k < nbytes) begin
                last_xor[8*k +: 8] = msg_data_i[8*k +: 8];
            end else if (k == nbytes) begin
                last_xor[8*k +: 8] = DSUFFIX;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        lane_cnt_d   = lane_cnt_q;
        pad_pend_d   = pad_pend_q;
        last_seen_d  = last_seen_q;
        msg_ready_o  = 1'b0;
        state_clr_o  = 1'b0;
        lane_we_o    = 1'b0;
        lane_idx_o   = '0;
        lane_xor_o   = '0;
        perm_start_o = 1'b0;
        dig_valid_o  = 1'b0;
        dig_data_o   = '0;
        dig_last_o   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (msg_valid_i) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                state_clr_o = 1'b1;
                lane_cnt_d  = '0;
                state_d     = S_ABSORB;
            end
            S_ABSORB: begin
                msg_ready_o = 1'b1;
                lane_idx_o  = lane_cnt_q;
                if (msg_valid_i) begin
                    lane_we_o  = 1'b1;
                    lane_cnt_d = lane_cnt_q + 5'd1;
                    if (msg_last_i && msg_bytes_i < 4'd8) begin
                        lane_xor_o = last_xor;
                        state_d    = S_FINAL;
                    end else if (msg_last_i) begin
                        // Full last lane: the suffix needs a lane of its own, possibly after a permutation.
                        lane_xor_o = msg_data_i;
                        pad_pend_d = 1'b1;
                        state_d    = (lane_cnt_q == LAST_RATE) ? S_PERM_REQ : S_PAD;
                    end else begin
                        lane_xor_o = msg_data_i;
                        if (lane_cnt_q == LAST_RATE) state_d = S_PERM_REQ;
                    end
                end
            end
            S_PAD: begin
                lane_we_o  = 1'b1;
                lane_idx_o = lane_cnt_q;
                lane_xor_o = {56'd0, DSUFFIX};
                pad_pend_d = 1'b0;
                state_d    = S_FINAL;
            end
            S_FINAL: begin
                lane_we_o   = 1'b1;
                lane_idx_o  = LAST_RATE;
                lane_xor_o  = {1'b1, 63'd0};
                last_seen_d = 1'b1;
                state_d     = S_PERM_REQ;
            end
            S_PERM_REQ: begin
                if (perm_ready_i) begin
                    perm_start_o = 1'b1;
                    state_d      = S_PERM_WAIT;
                end
            end
            S_PERM_WAIT: begin
                if (perm_done_i) begin
                    lane_cnt_d = '0;
                    if (pad_pend_q)       state_d = S_PAD;
                    else if (last_seen_q) state_d = S_SQUEEZE;
                    else                  state_d = S_ABSORB;
                end
            end
            S_SQUEEZE: begin
                lane_idx_o  = lane_cnt_q;
                dig_valid_o = 1'b1;
                dig_data_o  = lane_rdata_i;
                dig_last_o  = (lane_cnt_q == LAST_OUT);
                if (dig_ready_i) begin
                    if (lane_cnt_q == LAST_OUT) begin
                        last_seen_d = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        lane_cnt_d = lane_cnt_q + 5'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o = (state_q != S_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            lane_cnt_q  <= '0;
            pad_pend_q  <= 1'b0;
            last_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_cnt_q  <= lane_cnt_d;
            pad_pend_q  <= pad_pend_d;
            last_seen_q <= last_seen_d;
        end
    end

endmodule

// File: doc/keccak_sponge_ctrl.md
Name: keccak_sponge_ctrl

Overview:
- Sponge front-end sitting directly upstream of the Keccak permutation control unit. Absorbs a 64-bit message lane stream into the state's rate portion by XOR-write, applies pad10*1 with a configurable domain suffix, and pulses a permutation start per block.
- Waits for the permutation-done interrupt between blocks, then squeezes the digest lanes out on a valid/ready stream. Single-squeeze only (digest ≤ rate).

Parameters:
RATE_LANES, 17, rate in 64-bit lanes (17 = SHA3-256), legal 1..24
OUT_LANES, 4, digest length in lanes, legal 1..RATE_LANES
DSUFFIX, 8'h06, domain-separation byte XORed right after the last message byte

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
msg_valid_i  in  1  message lane valid
msg_ready_o  out  1  message lane accepted when valid&ready
msg_data_i  in  64  message lane, byte k = bits [8k+7:8k]
msg_last_i  in  1  final lane of message
msg_bytes_i  in  4  valid bytes in last lane, 0..8; ignored unless last
state_clr_o  out  1  one-cycle pulse: zero entire Keccak state
lane_we_o  out  1  XOR lane_xor_o into state lane lane_idx_o
lane_idx_o  out  5  lane index for XOR-write or read
lane_xor_o  out  64  XOR data
lane_rdata_i  in  64  combinational read of lane lane_idx_o
perm_ready_i  in  1  permutation unit idle
perm_start_o  out  1  one-cycle start pulse to permutation unit
perm_done_i  in  1  one-cycle completion pulse (interrupt)
dig_valid_o  out  1  digest lane valid
dig_ready_i  in  1  digest sink ready
dig_data_o  out  64  digest lane (= lane_rdata_i)
dig_last_o  out  1  final digest lane
busy_o  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, lane_cnt=0, pad_pend=0, last_seen=0. Reset mid-operation aborts immediately. State memory is not cleared by reset; the next message's CLEAR handles it.
- IDLE: on msg_valid_i=1, go to CLEAR. The lane is not consumed; msg_ready_o stays 0.
- CLEAR: state_clr_o=1 for exactly one cycle, lane_cnt<=0, then ABSORB.
- ABSORB: msg_ready_o=1. Each handshake drives lane_we_o=1 with lane_idx_o=lane_cnt in the same cycle, then lane_cnt++. Throughput is one lane per cycle.
  - Non-last lane: lane_xor_o = msg_data_i.
  - Last lane with msg_bytes_i<8: lane_xor_o = (msg_data_i masked to low msg_bytes_i bytes) | (DSUFFIX << 8*msg_bytes_i). Go to FINAL.
  - Last lane with msg_bytes_i=8: lane_xor_o = msg_data_i, set pad_pend=1. Go to PAD, or to PERM_REQ if lane_cnt was RATE_LANES-1.
  - Non-last lane written at lane_cnt=RATE_LANES-1: go to PERM_REQ.
- PAD: one write at lane_cnt, lane_xor_o = DSUFFIX in byte 0, clear pad_pend, go to FINAL.
- FINAL: one write at lane RATE_LANES-1 with lane_xor_o = 64'h8000_0000_0000_0000. Set last_seen=1, go to PERM_REQ. If the suffix landed in lane RATE_LANES-1, the two separate XORs compose (e.g. 0x86 in the top byte when DSUFFIX=0x06 and msg_bytes=7).
- PERM_REQ: when perm_ready_i=1, perm_start_o=1 for one cycle, then PERM_WAIT. Otherwise hold with no pulse.
- PERM_WAIT: wait for perm_done_i, then lane_cnt<=0 and:
  - pad_pend=1: go to PAD, writing lane 0.
  - last_seen=1: go to SQUEEZE.
  - otherwise: go to ABSORB.
- SQUEEZE: lane_idx_o=lane_cnt, dig_valid_o=1, dig_data_o=lane_rdata_i, dig_last_o=(lane_cnt==OUT_LANES-1).
  - On handshake, lane_cnt++.
  - After the last handshake, clear last_seen and go to IDLE.
  - dig_data_o is stable while stalled.
- lane_we_o=1 only in ABSORB (on handshake), PAD and FINAL. lane_xor_o=0 whenever lane_we_o=0.
- perm_done_i outside PERM_WAIT is ignored.

Test Plan:
- Empty message (valid, last, bytes=0): CLEAR pulse; lane0 ^= 0x06; lane16 ^= 0x8000_0000_0000_0000; one perm_start_o; then 4 digest lanes with dig_last_o on the 4th; back to IDLE.
- 3-byte last lane, data 0xFFFF_FFFF_FFCC_BBAA: lane_xor_o = 0x0000_0000_06CC_BBAA at lane0; FINAL writes lane16; exactly one permutation.
- 17 full lanes, last on the 17th with bytes=8: perm_start after lane16. After perm_done_i: PAD writes lane0 ^= 0x06, FINAL writes lane16; second perm_start; then squeeze. Total of two permutations.
- 18-lane message: perm after lane16, absorb resumes at lane_idx 0 with a new ABSORB block; msg_ready_o low from the PERM_REQ entry until perm_done_i.
- perm_ready_i held low 5 cycles in PERM_REQ: no perm_start_o; single pulse on the cycle perm_ready_i rises. dig_ready_i toggled 1/0: each digest lane delivered exactly once, in order 0..3.
- rst_ni asserted during PERM_WAIT: all outputs 0 asynchronously. The next message produces a fresh CLEAR pulse and correct absorb from lane 0.
